// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the F-stage fetch sequencer: FSM state encoding,
// default PC vectors and the PC increment helper.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_INIT_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC  = 32'h0000_4180;
  localparam int          DEF_TIMEOUT = 16;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Saturating count of consecutive un-acked request cycles; raises a sticky
// error flag once the count reaches TIMEOUT.
module fetch_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic fetch_err
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  logic [CW-1:0] wait_cnt_reg;
  logic [CW-1:0] wait_cnt_next;

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (req && ack) begin
      wait_cnt_next = '0;
    end else if (req && (wait_cnt_reg != CNT_MAX)) begin
      wait_cnt_next = wait_cnt_reg + CW'(1);
    end
  end

  // The flag sets on the same edge the counter lands on TIMEOUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg <= '0;
      fetch_err    <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      if (wait_cnt_next == CNT_MAX) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register, runs the instruction-memory
// req/ack handshake and holds one fetched instruction for the D stage.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] INIT_PC = DEF_INIT_PC,
  parameter logic [31:0] EXC_PC  = DEF_EXC_PC,
  parameter int          TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  output logic        pc_we,
  output logic [31:0] next_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_err
);

  fetch_state_e state_reg;
  fetch_state_e state_next;

  logic        redir_v_reg;
  logic [31:0] redir_pc_reg;

  logic can_accept;
  logic complete;
  logic flush;

  assign can_accept = ~instr_valid | ~stall;
  assign im_addr    = pc_f;

  always_comb begin
    state_next = state_reg;
    im_req     = 1'b0;
    pc_we      = 1'b0;
    next_pc    = pc_inc(pc_f);
    complete   = 1'b0;
    flush      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (exc_valid) begin
          flush   = 1'b1;
          pc_we   = 1'b1;
          next_pc = EXC_PC;
        end else begin
          im_req = can_accept;
          if (can_accept) begin
            if (im_ack) begin
              complete = 1'b1;
            end else begin
              state_next = ST_BUSY;
            end
          end
        end
      end

      ST_BUSY: begin
        im_req = 1'b1;
        if (exc_valid) begin
          flush = 1'b1;
          if (im_ack) begin
            pc_we      = 1'b1;
            next_pc    = EXC_PC;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DROP;
          end
        end else if (im_ack) begin
          complete = 1'b1;
        end
      end

      // Wrong-path request still outstanding; its data is thrown away.
      ST_DROP: begin
        im_req = 1'b1;
        if (im_ack) begin
          pc_we      = 1'b1;
          next_pc    = EXC_PC;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A same-cycle redirect takes effect directly; otherwise a latched one.
    if (complete) begin
      pc_we      = 1'b1;
      state_next = ST_IDLE;
      if (redirect_valid) begin
        next_pc = redirect_pc;
      end else if (redir_v_reg) begin
        next_pc = redir_pc_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      redir_v_reg  <= 1'b0;
      redir_pc_reg <= INIT_PC;
      instr_valid  <= 1'b0;
      instr        <= '0;
      instr_pc     <= INIT_PC;
    end else begin
      state_reg <= state_next;

      if (exc_valid || complete) begin
        redir_v_reg <= 1'b0;
      end else if (redirect_valid) begin
        redir_v_reg  <= 1'b1;
        redir_pc_reg <= redirect_pc;
      end

      // The slot is always free at completion, so a load never loses data.
      if (flush) begin
        instr_valid <= 1'b0;
      end else if (complete) begin
        instr_valid <= 1'b1;
        instr       <= im_rdata;
        instr_pc    <= pc_f;
      end else if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

  fetch_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .req      (im_req),
    .ack      (im_req & im_ack),
    .fetch_err(fetch_err)
  );

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the F stage. Drives the PC register's write enable and next-PC value, and runs a req/ack handshake to a variable-latency instruction memory. Buffers one fetched instruction in an F/D output slot, honouring the D-stage stall. Applies branch/jump redirects after the delay slot and flushes on exceptions.

Parameters:
INIT_PC, 32'h0000_3000, reset PC; instr_pc reset value
EXC_PC, 32'h0000_4180, exception handler entry
TIMEOUT, 16, consecutive un-acked request cycles before fetch_err sets (min 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
pc_f  in  32  current PC from PC register
pc_we  out  1  PC register write enable (combinational)
next_pc  out  32  PC register next value (combinational)
im_req  out  1  instruction memory request
im_addr  out  32  memory address; always equals pc_f
im_ack  in  1  memory response valid; only meaningful while im_req=1
im_rdata  in  32  instruction word, valid with im_ack
stall  in  1  D stage cannot accept the output slot this cycle
redirect_valid  in  1  one-cycle pulse: branch/jump taken in D
redirect_pc  in  32  redirect target
exc_valid  in  1  one-cycle pulse: flush and vector to EXC_PC
instr_valid  out  1  output slot holds an instruction (registered)
instr  out  32  slot instruction (registered)
instr_pc  out  32  slot PC (registered)
fetch_err  out  1  sticky timeout flag (registered)

Behaviour:
- Reset (reset=0, async): state IDLE, instr_valid=0, instr=0, instr_pc=INIT_PC, redir_v=0, wait_cnt=0, fetch_err=0.
- States: IDLE (nothing outstanding), BUSY (request outstanding, result kept), DROP (request outstanding, result discarded).
- Memory protocol: once im_req rises it stays high until im_ack, with im_addr stable. Ack may arrive in the same cycle as the request (zero-wait). At most one request is outstanding.
- can_accept = ~instr_valid | ~stall.
- Slot consumed = instr_valid & ~stall. It clears at the edge unless reloaded by a completion in the same cycle.
- Completion (ack accepted in IDLE or BUSY):
  - instr<=im_rdata, instr_pc<=pc_f, instr_valid<=1.
  - pc_we=1; next_pc = redirect_pc if redirect_valid this cycle, else redir_pc if redir_v, else pc_f+4 (mod 2^32).
  - redir_v<=0; go to IDLE.
- IDLE:
  - If exc_valid: pc_we=1, next_pc=EXC_PC, instr_valid<=0, im_req=0.
  - Else im_req=can_accept. If ack in the same cycle, complete; otherwise go to BUSY.
- BUSY: im_req=1.
  - exc_valid with ack: discard; pc_we=1, next_pc=EXC_PC; go to IDLE.
  - exc_valid without ack: go to DROP.
  - Both cases: instr_valid<=0.
- DROP: im_req=1. On ack: discard; pc_we=1, next_pc=EXC_PC; go to IDLE.
- Redirect:
  - redirect_valid without a same-cycle completion sets redir_v/redir_pc; a later pulse overwrites.
  - The in-flight or next fetch (the delay slot) is delivered normally.
  - exc_valid clears redir_v and has priority over a same-cycle redirect.
- A repeated exc_valid while in DROP has no further effect.
- When pc_we=0, next_pc = pc_f+4 (don't-care value, but defined).
- Timeout:
  - wait_cnt increments each cycle with im_req=1 & ~im_ack, saturating at TIMEOUT.
  - wait_cnt clears on ack.
  - fetch_err<=1 when wait_cnt reaches TIMEOUT; stays set until reset.
- Stall never blocks an outstanding request. The slot is guaranteed free at completion, because issue requires can_accept and only one request is outstanding.

Decomposition:
- Shared constants header: state encodings (IDLE/BUSY/DROP), INIT_PC, EXC_PC defaults. The PC register uses the same INIT_PC.
- One optional sub-module: fetch_timeout_cnt (saturating wait counter plus sticky flag).
- FSM, redirect latch and output slot stay in fetch_ctrl.

Test Plan:
1. Zero-wait memory (ack=req, rdata=addr^32'hFFFF), stall=0, release reset -> pc_f advances 0x3000, 0x3004, 0x3008 one per cycle; instr_pc follows one cycle later, instr_valid continuous.
2. Two-cycle-latency memory -> im_req high and im_addr=0x3000 held until ack; pc_we exactly once, at the ack cycle, with next_pc=0x3004.
3. instr_valid=1 (instr_pc=0x3004) with stall held 3 cycles -> outputs stable, im_req=0, pc_we=0; after stall drops the slot drains and fetch of 0x3008 issues.
4. redirect_valid with redirect_pc=0x3100 while BUSY on 0x3008 -> 0x3008 delivered; next_pc=0x3100. Repeat with the redirect in the ack cycle -> same result.
5. exc_valid in BUSY (no ack) -> instr_valid=0, DROP entered; the later ack is discarded and next_pc=0x4180. exc_valid in the same cycle as a redirect -> 0x4180 wins.
6. Ack withheld 16 cycles (TIMEOUT=16) -> fetch_err=1 and stays 1 after ack. Drive reset low mid-BUSY -> all outputs at reset values immediately, without waiting for a clock edge.
